// File: rtl/sdram_pkg.sv
// Shared definitions for the SDR SDRAM controller: command encodings,
// arbiter state encoding and default bus widths.
package sdram_pkg;

    // Default bus widths
    localparam int DEF_ADDR_W = 13;
    localparam int DEF_BA_W   = 2;
    localparam int DEF_DQ_W   = 16;

    // SDRAM commands as {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;
    localparam logic [3:0] CMD_BST  = 4'b0110;

    // Arbiter FSM states
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/sdram_arbiter.sv
// Central SDRAM command-bus scheduler: holds the bus for the init sequence,
// then grants it to refresh (highest priority) or to write/read, which
// alternate on ties. The granted source's command/bank/address drive the pins
// and the DQ tristate is driven only during write data cycles.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BA_W   = DEF_BA_W,
    parameter int DQ_W   = DEF_DQ_W
) (
    input  logic              sys_clk_i,
    input  logic              rst_i,
    input  logic              init_end_i,
    input  logic [3:0]        init_cmd_i,
    input  logic [BA_W-1:0]   init_ba_i,
    input  logic [ADDR_W-1:0] init_addr_i,
    input  logic              aref_req_i,
    input  logic              aref_end_i,
    input  logic [3:0]        aref_cmd_i,
    input  logic [BA_W-1:0]   aref_ba_i,
    input  logic [ADDR_W-1:0] aref_addr_i,
    output logic              aref_en_o,
    input  logic              wr_req_i,
    input  logic              wr_end_i,
    input  logic [3:0]        wr_cmd_i,
    input  logic [BA_W-1:0]   wr_ba_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DQ_W-1:0]   wr_data_i,
    input  logic              wr_sdram_en_i,
    output logic              wr_en_o,
    input  logic              rd_req_i,
    input  logic              rd_end_i,
    input  logic [3:0]        rd_cmd_i,
    input  logic [BA_W-1:0]   rd_ba_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_en_o,
    output logic [DQ_W-1:0]   rd_data_o,
    output logic              sdram_cke_o,
    output logic              sdram_cs_n_o,
    output logic              sdram_ras_n_o,
    output logic              sdram_cas_n_o,
    output logic              sdram_we_n_o,
    output logic [BA_W-1:0]   sdram_ba_o,
    output logic [ADDR_W-1:0] sdram_addr_o,
    inout  wire  [DQ_W-1:0]   sdram_dq_io
);

    arb_state_t        state_r;
    arb_state_t        state_nxt_s;
    logic              last_wr_r;
    logic              aref_en_r;
    logic              wr_en_r;
    logic              rd_en_r;
    logic [3:0]        cmd_s;
    logic [BA_W-1:0]   ba_s;
    logic [ADDR_W-1:0] addr_s;
    logic              dq_oe_s;

    // State register, grant flags and write/read fairness flag
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_r   <= ST_INIT;
            last_wr_r <= 1'b0;
            aref_en_r <= 1'b0;
            wr_en_r   <= 1'b0;
            rd_en_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            aref_en_r <= (state_nxt_s == ST_AREF);
            wr_en_r   <= (state_nxt_s == ST_WRITE);
            rd_en_r   <= (state_nxt_s == ST_READ);
            if ((state_r == ST_ARBIT) && (state_nxt_s == ST_WRITE)) begin
                last_wr_r <= 1'b1;
            end else if ((state_r == ST_ARBIT) && (state_nxt_s == ST_READ)) begin
                last_wr_r <= 1'b0;
            end else begin
                last_wr_r <= last_wr_r;
            end
        end
    end

    // Next-state: refresh first, then write/read alternating on a tie;
    // a granted state only leaves on its own end strobe
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (init_end_i) begin
                    state_nxt_s = ST_ARBIT;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_ARBIT: begin
                if (aref_req_i) begin
                    state_nxt_s = ST_AREF;
                end else if (wr_req_i && rd_req_i) begin
                    state_nxt_s = last_wr_r ? ST_READ : ST_WRITE;
                end else if (wr_req_i) begin
                    state_nxt_s = ST_WRITE;
                end else if (rd_req_i) begin
                    state_nxt_s = ST_READ;
                end else begin
                    state_nxt_s = ST_ARBIT;
                end
            end
            ST_AREF: begin
                if (aref_end_i) begin
                    state_nxt_s = ST_ARBIT;
                end else begin
                    state_nxt_s = ST_AREF;
                end
            end
            ST_WRITE: begin
                if (wr_end_i) begin
                    state_nxt_s = ST_ARBIT;
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            ST_READ: begin
                if (rd_end_i) begin
                    state_nxt_s = ST_ARBIT;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            default: begin
                state_nxt_s = ST_INIT;
            end
        endcase
    end

    // Pin mux: the owner of the bus drives cmd/ba/addr; idle bus issues NOP
    always_comb begin
        cmd_s  = CMD_NOP;
        ba_s   = {BA_W{1'b1}};
        addr_s = {ADDR_W{1'b1}};
        case (state_r)
            ST_INIT: begin
                cmd_s  = init_cmd_i;
                ba_s   = init_ba_i;
                addr_s = init_addr_i;
            end
            ST_ARBIT: begin
                cmd_s  = CMD_NOP;
                ba_s   = {BA_W{1'b1}};
                addr_s = {ADDR_W{1'b1}};
            end
            ST_AREF: begin
                cmd_s  = aref_cmd_i;
                ba_s   = aref_ba_i;
                addr_s = aref_addr_i;
            end
            ST_WRITE: begin
                cmd_s  = wr_cmd_i;
                ba_s   = wr_ba_i;
                addr_s = wr_addr_i;
            end
            ST_READ: begin
                cmd_s  = rd_cmd_i;
                ba_s   = rd_ba_i;
                addr_s = rd_addr_i;
            end
            default: begin
                cmd_s  = CMD_NOP;
                ba_s   = {BA_W{1'b1}};
                addr_s = {ADDR_W{1'b1}};
            end
        endcase
    end

    assign dq_oe_s = (state_r == ST_WRITE) && wr_sdram_en_i;

    assign sdram_dq_io   = dq_oe_s ? wr_data_i : {DQ_W{1'bz}};
    assign rd_data_o     = sdram_dq_io;
    assign sdram_cke_o   = 1'b1;
    assign sdram_cs_n_o  = cmd_s[3];
    assign sdram_ras_n_o = cmd_s[2];
    assign sdram_cas_n_o = cmd_s[1];
    assign sdram_we_n_o  = cmd_s[0];
    assign sdram_ba_o    = ba_s;
    assign sdram_addr_o  = addr_s;
    assign aref_en_o     = aref_en_r;
    assign wr_en_o       = wr_en_r;
    assign rd_en_o       = rd_en_r;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter. The bench models the SDRAM
// DQ side: whenever the arbiter should not drive DQ the bench drives a known
// pattern, so any stray arbiter drive shows up as a corrupted bus value.
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_end;
    logic [3:0]  init_cmd  = 4'b0010;
    logic [1:0]  init_ba   = 2'b01;
    logic [12:0] init_addr = 13'h0400;
    logic        aref_req, aref_end;
    logic [3:0]  aref_cmd  = 4'b0001;
    logic [1:0]  aref_ba   = 2'b10;
    logic [12:0] aref_addr = 13'h0111;
    logic        aref_en;
    logic        wr_req, wr_end;
    logic [3:0]  wr_cmd    = 4'b0100;
    logic [1:0]  wr_ba     = 2'b00;
    logic [12:0] wr_addr   = 13'h0222;
    logic [15:0] wr_data;
    logic        wr_sdram_en;
    logic        wr_en;
    logic        rd_req, rd_end;
    logic [3:0]  rd_cmd    = 4'b0101;
    logic [1:0]  rd_ba     = 2'b11;
    logic [12:0] rd_addr   = 13'h0333;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        cke, cs_n, ras_n, cas_n, we_n;
    logic [1:0]  ba;
    logic [12:0] addr;
    wire  [15:0] dq_bus;
    logic        model_oe;
    logic [15:0] model_data;

    int n_cmp = 0;
    int n_err = 0;

    assign dq_bus = model_oe ? model_data : 16'hzzzz;

    always #5 clk = ~clk;

    sdram_arbiter dut (
        .sys_clk_i     (clk),
        .rst_i         (rst),
        .init_end_i    (init_end),
        .init_cmd_i    (init_cmd),
        .init_ba_i     (init_ba),
        .init_addr_i   (init_addr),
        .aref_req_i    (aref_req),
        .aref_end_i    (aref_end),
        .aref_cmd_i    (aref_cmd),
        .aref_ba_i     (aref_ba),
        .aref_addr_i   (aref_addr),
        .aref_en_o     (aref_en),
        .wr_req_i      (wr_req),
        .wr_end_i      (wr_end),
        .wr_cmd_i      (wr_cmd),
        .wr_ba_i       (wr_ba),
        .wr_addr_i     (wr_addr),
        .wr_data_i     (wr_data),
        .wr_sdram_en_i (wr_sdram_en),
        .wr_en_o       (wr_en),
        .rd_req_i      (rd_req),
        .rd_end_i      (rd_end),
        .rd_cmd_i      (rd_cmd),
        .rd_ba_i       (rd_ba),
        .rd_addr_i     (rd_addr),
        .rd_en_o       (rd_en),
        .rd_data_o     (rd_data),
        .sdram_cke_o   (cke),
        .sdram_cs_n_o  (cs_n),
        .sdram_ras_n_o (ras_n),
        .sdram_cas_n_o (cas_n),
        .sdram_we_n_o  (we_n),
        .sdram_ba_o    (ba),
        .sdram_addr_o  (addr),
        .sdram_dq_io   (dq_bus)
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; init_end = 1'b0;
        aref_req = 1'b0; aref_end = 1'b0;
        wr_req = 1'b0; wr_end = 1'b0; wr_data = 16'h0000; wr_sdram_en = 1'b0;
        rd_req = 1'b0; rd_end = 1'b0;
        model_oe = 1'b1; model_data = 16'h3C3C;
        repeat (3) tick();
        n_cmp++;
        if ({aref_en, wr_en, rd_en} !== 3'b000) begin
            n_err++; $display("FAIL reset_grants: got %b want 000", {aref_en, wr_en, rd_en});
        end
        n_cmp++;
        if (cke !== 1'b1) begin
            n_err++; $display("FAIL reset_cke: got %b want 1", cke);
        end
        n_cmp++;
        if ({cs_n, ras_n, cas_n, we_n, ba, addr} !== {4'b0010, 2'b01, 13'h0400}) begin
            n_err++; $display("FAIL reset_pins: got %h want init", {cs_n, ras_n, cas_n, we_n, ba, addr});
        end
        n_cmp++;
        if (dq_bus !== 16'h3C3C) begin
            n_err++; $display("FAIL reset_dq: got %h want 3c3c", dq_bus);
        end
    endtask

    task automatic test_init();
        rst = 1'b0;
        for (int c = 0; c < 200; c++) begin
            init_cmd = (c[0] == 1'b1) ? 4'b0000 : 4'b0010;
            init_addr = 13'(c);
            tick();
            n_cmp++;
            if ({cs_n, ras_n, cas_n, we_n, addr} !== {init_cmd, init_addr}) begin
                n_err++; $display("FAIL init_mirror: cycle %0d got %h want %h", c, {cs_n, ras_n, cas_n, we_n, addr}, {init_cmd, init_addr});
            end
        end
        init_end = 1'b1;
        tick();
        init_end = 1'b0;
        n_cmp++;
        if ({cs_n, ras_n, cas_n, we_n, ba, addr} !== {4'b0111, 2'b11, 13'h1FFF}) begin
            n_err++; $display("FAIL arbit_nop: got %h want 7 3 1fff", {cs_n, ras_n, cas_n, we_n, ba, addr});
        end
        n_cmp++;
        if ({aref_en, wr_en, rd_en} !== 3'b000) begin
            n_err++; $display("FAIL arbit_grants: got %b want 000", {aref_en, wr_en, rd_en});
        end
        tick();
        n_cmp++;
        if ({cs_n, ras_n, cas_n, we_n} !== 4'b0111) begin
            n_err++; $display("FAIL init_end_drop: got %b want 0111", {cs_n, ras_n, cas_n, we_n});
        end
    endtask

    task automatic test_aref_priority();
        aref_req = 1'b1; wr_req = 1'b1;
        tick();
        n_cmp++;
        if ({aref_en, wr_en, rd_en} !== 3'b100) begin
            n_err++; $display("FAIL aref_first: got %b want 100", {aref_en, wr_en, rd_en});
        end
        n_cmp++;
        if ({cs_n, ras_n, cas_n, we_n, ba, addr} !== {4'b0001, 2'b10, 13'h0111}) begin
            n_err++; $display("FAIL aref_pins: got %h want aref", {cs_n, ras_n, cas_n, we_n, ba, addr});
        end
        aref_req = 1'b0;
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        n_cmp++;
        if ({aref_en, wr_en} !== 2'b10) begin
            n_err++; $display("FAIL aref_hold: got %b want 10", {aref_en, wr_en});
        end
        aref_end = 1'b1;
        tick();
        aref_end = 1'b0;
        n_cmp++;
        if ({aref_en, wr_en, rd_en, cs_n, ras_n, cas_n, we_n} !== 7'b000_0111) begin
            n_err++; $display("FAIL aref_to_nop: got %b want 0000111", {aref_en, wr_en, rd_en, cs_n, ras_n, cas_n, we_n});
        end
        tick();
        n_cmp++;
        if ({aref_en, wr_en, rd_en} !== 3'b010) begin
            n_err++; $display("FAIL wr_after_aref: got %b want 010", {aref_en, wr_en, rd_en});
        end
        n_cmp++;
        if ({cs_n, ras_n, cas_n, we_n, ba, addr} !== {4'b0100, 2'b00, 13'h0222}) begin
            n_err++; $display("FAIL wr_pins: got %h want wr", {cs_n, ras_n, cas_n, we_n, ba, addr});
        end
        wr_req = 1'b0; wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_g;
        exp_g = 3'b001;
        wr_req = 1'b1; rd_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            tick();
            n_cmp++;
            if ({aref_en, wr_en, rd_en} !== exp_g) begin
                n_err++; $display("FAIL alt_grant: grant %0d got %b want %b", g, {aref_en, wr_en, rd_en}, exp_g);
            end
            if (exp_g == 3'b010) wr_end = 1'b1;
            else rd_end = 1'b1;
            tick();
            wr_end = 1'b0; rd_end = 1'b0;
            n_cmp++;
            if ({aref_en, wr_en, rd_en, cs_n, ras_n, cas_n, we_n} !== 7'b000_0111) begin
                n_err++; $display("FAIL alt_nop: gap %0d got %b want 0000111", g, {aref_en, wr_en, rd_en, cs_n, ras_n, cas_n, we_n});
            end
            exp_g = (exp_g == 3'b010) ? 3'b001 : 3'b010;
        end
        wr_req = 1'b0; rd_req = 1'b0;
    endtask

    task automatic test_dq_write();
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        n_cmp++;
        if (dq_bus !== 16'h3C3C) begin
            n_err++; $display("FAIL dq_idle_write: got %h want 3c3c", dq_bus);
        end
        model_oe = 1'b0; wr_sdram_en = 1'b1; wr_data = 16'hA5A5;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++;
            if (dq_bus !== 16'hA5A5) begin
                n_err++; $display("FAIL dq_drive: cycle %0d got %h want a5a5", c, dq_bus);
            end
        end
        wr_sdram_en = 1'b0; model_oe = 1'b1;
        rd_end = 1'b1;
        tick();
        rd_end = 1'b0;
        n_cmp++;
        if (dq_bus !== 16'h3C3C) begin
            n_err++; $display("FAIL dq_release: got %h want 3c3c", dq_bus);
        end
        n_cmp++;
        if ({wr_en, rd_en, cs_n, ras_n, cas_n, we_n} !== 6'b10_0100) begin
            n_err++; $display("FAIL rd_end_ignored: got %b want 100100", {wr_en, rd_en, cs_n, ras_n, cas_n, we_n});
        end
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        wr_sdram_en = 1'b1;
        #1;
        n_cmp++;
        if (wr_en !== 1'b0 || dq_bus !== 16'h3C3C) begin
            n_err++; $display("FAIL wr_end_release: got en=%b dq=%h want en=0 dq=3c3c", wr_en, dq_bus);
        end
        wr_sdram_en = 1'b0;
    endtask

    task automatic test_read_and_reset();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        n_cmp++;
        if ({aref_en, wr_en, rd_en} !== 3'b001) begin
            n_err++; $display("FAIL rd_grant: got %b want 001", {aref_en, wr_en, rd_en});
        end
        model_data = 16'h5A5A;
        #1;
        n_cmp++;
        if (rd_data !== 16'h5A5A) begin
            n_err++; $display("FAIL rd_data_a: got %h want 5a5a", rd_data);
        end
        model_data = 16'h1234;
        wr_sdram_en = 1'b1;
        #1;
        n_cmp++;
        if (rd_data !== 16'h1234) begin
            n_err++; $display("FAIL rd_data_b: got %h want 1234", rd_data);
        end
        rst = 1'b1;
        init_cmd = 4'b0010; init_addr = 13'h0400;
        tick();
        n_cmp++;
        if ({aref_en, wr_en, rd_en} !== 3'b000) begin
            n_err++; $display("FAIL rst_grants: got %b want 000", {aref_en, wr_en, rd_en});
        end
        n_cmp++;
        if ({cs_n, ras_n, cas_n, we_n, ba, addr} !== {4'b0010, 2'b01, 13'h0400}) begin
            n_err++; $display("FAIL rst_pins: got %h want init", {cs_n, ras_n, cas_n, we_n, ba, addr});
        end
        n_cmp++;
        if (dq_bus !== 16'h1234) begin
            n_err++; $display("FAIL rst_dq: got %h want 1234", dq_bus);
        end
        wr_sdram_en = 1'b0;
        rst = 1'b0;
        rd_req = 1'b1; wr_req = 1'b1;
        tick();
        n_cmp++;
        if ({aref_en, wr_en, rd_en, cs_n, ras_n, cas_n, we_n} !== 7'b000_0010) begin
            n_err++; $display("FAIL reinit_wait: got %b want 0000010", {aref_en, wr_en, rd_en, cs_n, ras_n, cas_n, we_n});
        end
        init_end = 1'b1;
        tick();
        init_end = 1'b0;
        tick();
        n_cmp++;
        if ({aref_en, wr_en, rd_en} !== 3'b010) begin
            n_err++; $display("FAIL reinit_wr_first: got %b want 010", {aref_en, wr_en, rd_en});
        end
        rd_req = 1'b0; wr_req = 1'b0;
    endtask

    // Directed test sequence
    initial begin
        test_reset();
        test_init();
        test_aref_priority();
        test_back_to_back();
        test_dq_write();
        test_read_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
